// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI responder.
package spi_pkg;
    localparam int SPI_BYTE_W   = 8;
    localparam int ERR_UNDERRUN = 0;
    localparam int ERR_OVERRUN  = 1;
    localparam int ERR_ABORT    = 2;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;
endpackage

// File: rtl/spi_rx_fifo.sv
// RX byte FIFO with show-ahead head output; built only with SPI_SLAVE_RXFIFO_EN.
`ifdef SPI_SLAVE_RXFIFO_EN
module spi_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_pop;
    logic         do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Storage and pointer update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end
endmodule
`endif

// File: rtl/spi_sync_edge.sv
// Synchroniser for one asynchronous pin plus single-cycle rise/fall strobes.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] chain;
    logic              hist;

    // Synchroniser chain followed by one history flop for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
            hist  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            hist  <= chain[STAGES-1];
        end
    end

    assign rise = chain[STAGES-1] & ~hist;
    assign fall = ~chain[STAGES-1] & hist;
endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder, MSB first, 8-bit frames, pins oversampled by clk.
// Define SPI_SLAVE_RXFIFO_EN to queue received bytes in an RX_DEPTH-entry FIFO.
module spi_slave
    import spi_pkg::*;
#(
    parameter logic [SPI_BYTE_W-1:0] TX_FILL     = 8'hFF,
    parameter int                    SYNC_STAGES = 2,
    parameter int                    RX_DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  SCK,
    input  logic                  CS,
    input  logic                  MoSi,
    output logic                  MiSo,
    input  logic [SPI_BYTE_W-1:0] DATAout,
    input  logic                  tx_load,
    output logic                  tx_full,
    output logic [SPI_BYTE_W-1:0] DATAin,
    output logic                  rx_valid,
    input  logic                  rx_ack,
    output logic                  busy,
    output logic [2:0]            err,
    input  logic                  err_clr
);
    if (!((SYNC_STAGES == 2 || SYNC_STAGES == 3) && (RX_DEPTH >= 2) &&
          ((RX_DEPTH & (RX_DEPTH - 1)) == 0))) begin : g_bad_params
        $error("spi_slave: SYNC_STAGES must be 2 or 3 and RX_DEPTH a power of 2");
    end

    spi_state_t              state;
    spi_state_t              state_next;
    logic                    sck_rise, sck_fall, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0]  mosi_chain;
    logic                    mosi_sync;
    logic                    start, frame_end, rx_bit, tx_fall;
    logic                    byte_done, reload, underrun, overrun, abort;
    logic [SPI_BYTE_W-1:0]   tx_hold, tx_shift, tx_src, rx_byte;
    logic [SPI_BYTE_W-2:0]   rx_shift;
    logic [2:0]              bit_cnt;
    logic                    reload_pending, fill_pending;
    logic [2:0]              err_evt;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sck_sync (
        .clk (clk), .rst (rst), .din (SCK), .rise (sck_rise), .fall (sck_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk (clk), .rst (rst), .din (CS), .rise (cs_rise), .fall (cs_fall)
    );

    // MoSi synchroniser, same depth as SCK so data lines up with sck_rise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mosi_chain <= '0;
        end else begin
            mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], MoSi};
        end
    end
    assign mosi_sync = mosi_chain[SYNC_STAGES-1];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-cycle frame events
    always_comb begin
        state_next = state;
        start      = 1'b0;
        frame_end  = 1'b0;
        rx_bit     = 1'b0;
        tx_fall    = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_next = ACTIVE;
                    start      = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_next = IDLE;
                    frame_end  = 1'b1;
                end else begin
                    state_next = ACTIVE;
                    rx_bit     = sck_rise;
                    tx_fall    = sck_fall;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign byte_done = rx_bit & (bit_cnt == 3'd7);
    assign reload    = start | byte_done;
    assign tx_src    = tx_full ? tx_hold : TX_FILL;
    assign rx_byte   = {rx_shift, mosi_sync};
    // A fill byte loaded at a byte boundary only counts as underrun once the
    // master starts clocking it out; a frame ending on the boundary is clean.
    assign underrun  = (start & ~tx_full) | (rx_bit & fill_pending);
    assign abort     = frame_end & (bit_cnt != 3'd0);
    assign busy      = (state == ACTIVE);

    // TX holding register; a load racing a reload lands in the holding slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_hold <= 8'h00;
            tx_full <= 1'b0;
        end else if (tx_load) begin
            tx_hold <= DATAout;
            tx_full <= 1'b1;
        end else if (reload) begin
            tx_full <= 1'b0;
        end
    end

    // Shift registers, bit counter and MiSo
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_shift       <= 8'h00;
            rx_shift       <= 7'h00;
            bit_cnt        <= 3'd0;
            MiSo           <= 1'b0;
            reload_pending <= 1'b0;
            fill_pending   <= 1'b0;
        end else if (start) begin
            tx_shift       <= tx_src;
            MiSo           <= tx_src[SPI_BYTE_W-1];
            bit_cnt        <= 3'd0;
            reload_pending <= 1'b0;
            fill_pending   <= 1'b0;
        end else if (frame_end) begin
            MiSo           <= 1'b0;
            bit_cnt        <= 3'd0;
            reload_pending <= 1'b0;
            fill_pending   <= 1'b0;
        end else if (rx_bit) begin
            rx_shift     <= rx_byte[SPI_BYTE_W-2:0];
            bit_cnt      <= bit_cnt + 3'd1;
            fill_pending <= byte_done & ~tx_full;
            if (byte_done) begin
                tx_shift       <= tx_src;
                reload_pending <= 1'b1;
            end
        end else if (tx_fall) begin
            if (reload_pending) begin
                MiSo           <= tx_shift[SPI_BYTE_W-1];
                reload_pending <= 1'b0;
            end else begin
                tx_shift <= {tx_shift[SPI_BYTE_W-2:0], 1'b0};
                MiSo     <= tx_shift[SPI_BYTE_W-2];
            end
        end
    end

`ifdef SPI_SLAVE_RXFIFO_EN
    logic fifo_empty;
    logic fifo_full;

    spi_rx_fifo #(.DEPTH(RX_DEPTH), .W(SPI_BYTE_W)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (byte_done),
        .din   (rx_byte),
        .pop   (rx_ack),
        .dout  (DATAin),
        .empty (fifo_empty),
        .full  (fifo_full)
    );
    assign rx_valid = ~fifo_empty;
    assign overrun  = byte_done & fifo_full & ~rx_ack;
`else
    // Single RX register; a completed byte always wins over rx_ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            DATAin   <= 8'h00;
            rx_valid <= 1'b0;
        end else if (byte_done) begin
            DATAin   <= rx_byte;
            rx_valid <= 1'b1;
        end else if (rx_ack) begin
            rx_valid <= 1'b0;
        end
    end
    assign overrun = byte_done & rx_valid & ~rx_ack;
`endif

    // Error event vector
    always_comb begin
        err_evt               = 3'b000;
        err_evt[ERR_UNDERRUN] = underrun;
        err_evt[ERR_OVERRUN]  = overrun;
        err_evt[ERR_ABORT]    = abort;
    end

    // Sticky error flags; a new event beats a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 3'b000;
        end else begin
            err <= (err_clr ? 3'b000 : err) | err_evt;
        end
    end
endmodule

// File: tb/tb_spi_slave.sv
// Directed self-checking bench for spi_slave acting as the SPI master (SCK = clk/8).
module tb_spi_slave;
    logic       clk;
    logic       rst;
    logic       SCK;
    logic       CS;
    logic       MoSi;
    logic       MiSo;
    logic [7:0] DATAout;
    logic       tx_load;
    logic       tx_full;
    logic [7:0] DATAin;
    logic       rx_valid;
    logic       rx_ack;
    logic       busy;
    logic [2:0] err;
    logic       err_clr;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] got;
    logic [7:0] got2;

    spi_slave dut (
        .clk      (clk),
        .rst      (rst),
        .SCK      (SCK),
        .CS       (CS),
        .MoSi     (MoSi),
        .MiSo     (MiSo),
        .DATAout  (DATAout),
        .tx_load  (tx_load),
        .tx_full  (tx_full),
        .DATAin   (DATAin),
        .rx_valid (rx_valid),
        .rx_ack   (rx_ack),
        .busy     (busy),
        .err      (err),
        .err_clr  (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_tx(input logic [7:0] b);
        DATAout = b;
        tx_load = 1'b1;
        wait_clks(1);
        tx_load = 1'b0;
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        wait_clks(1);
        rx_ack = 1'b0;
        wait_clks(1);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        wait_clks(1);
        err_clr = 1'b0;
        wait_clks(1);
    endtask

    task automatic cs_begin();
        CS = 1'b0;
        wait_clks(6);
    endtask

    task automatic cs_end();
        wait_clks(4);
        CS = 1'b1;
        wait_clks(6);
    endtask

    // Clock out nbits MSB-first, sampling MiSo as the master does on each rise
    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            MoSi = tx[7-i];
            wait_clks(4);
            rx = {rx[6:0], MiSo};
            SCK = 1'b1;
            wait_clks(4);
            SCK = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; SCK = 1'b0; CS = 1'b1; MoSi = 1'b0;
        DATAout = 8'h00; tx_load = 1'b0; rx_ack = 1'b0; err_clr = 1'b0;
        wait_clks(3);
        check("rst_miso", {7'd0, MiSo}, 8'h00);
        check("rst_datain", DATAin, 8'h00);
        check("rst_rx_valid", {7'd0, rx_valid}, 8'h00);
        check("rst_tx_full", {7'd0, tx_full}, 8'h00);
        check("rst_busy", {7'd0, busy}, 8'h00);
        check("rst_err", {5'd0, err}, 8'h00);
        rst = 1'b0;
        wait_clks(6);

        // 1: loaded TX byte, receive 3C
        load_tx(8'hA5);
        check("t1_tx_full_loaded", {7'd0, tx_full}, 8'h01);
        cs_begin();
        check("t1_busy", {7'd0, busy}, 8'h01);
        spi_bits(8'h3C, 8, got);
        cs_end();
        check("t1_miso_byte", got, 8'hA5);
        check("t1_datain", DATAin, 8'h3C);
        check("t1_rx_valid", {7'd0, rx_valid}, 8'h01);
        check("t1_tx_full", {7'd0, tx_full}, 8'h00);
        check("t1_err", {5'd0, err}, 8'h00);
        check("t1_busy_idle", {7'd0, busy}, 8'h00);
        check("t1_miso_idle", {7'd0, MiSo}, 8'h00);
        pulse_ack();
        check("t1_ack", {7'd0, rx_valid}, 8'h00);

        // 2: underrun sends fill byte
        cs_begin();
        spi_bits(8'h00, 8, got);
        cs_end();
        check("t2_miso_fill", got, 8'hFF);
        check("t2_datain", DATAin, 8'h00);
        check("t2_err", {5'd0, err}, 8'h01);
        pulse_clr();
        check("t2_err_clr", {5'd0, err}, 8'h00);
        pulse_ack();

        // 3: two bytes under one CS, no ack in between
        load_tx(8'h96);
        cs_begin();
        spi_bits(8'h11, 8, got);
        spi_bits(8'h22, 8, got2);
        cs_end();
        check("t3_miso_b0", got, 8'h96);
        check("t3_miso_b1", got2, 8'hFF);
`ifdef SPI_SLAVE_RXFIFO_EN
        check("t3_head0", DATAin, 8'h11);
        check("t3_err", {5'd0, err}, 8'h01);
        pulse_ack();
        check("t3_head1", DATAin, 8'h22);
        check("t3_valid1", {7'd0, rx_valid}, 8'h01);
        pulse_ack();
        check("t3_empty", {7'd0, rx_valid}, 8'h00);
`else
        check("t3_datain", DATAin, 8'h22);
        check("t3_err", {5'd0, err}, 8'h03);
        pulse_ack();
        check("t3_ack", {7'd0, rx_valid}, 8'h00);
`endif
        pulse_clr();

        // 4: abort after 5 rises, then a clean frame
        cs_begin();
        spi_bits(8'hF0, 5, got);
        cs_end();
        check("t4_err_abort", {5'd0, err}, 8'h05);
        check("t4_rx_valid", {7'd0, rx_valid}, 8'h00);
`ifdef SPI_SLAVE_RXFIFO_EN
        check("t4_datain", DATAin, 8'h3C);
`else
        check("t4_datain", DATAin, 8'h22);
`endif
        check("t4_busy", {7'd0, busy}, 8'h00);
        pulse_clr();
        load_tx(8'h12);
        load_tx(8'h81);
        cs_begin();
        spi_bits(8'hC3, 8, got);
        cs_end();
        check("t4_miso_overwrite", got, 8'h81);
        check("t4_datain_c3", DATAin, 8'hC3);
        check("t4_valid_c3", {7'd0, rx_valid}, 8'h01);
        check("t4_err_c3", {5'd0, err}, 8'h00);
        pulse_ack();

        // 5: reset mid-byte
        load_tx(8'hE7);
        cs_begin();
        spi_bits(8'hAA, 3, got);
        rst = 1'b1;
        #1;
        check("t5_miso", {7'd0, MiSo}, 8'h00);
        check("t5_busy", {7'd0, busy}, 8'h00);
        check("t5_tx_full", {7'd0, tx_full}, 8'h00);
        check("t5_err", {5'd0, err}, 8'h00);
        check("t5_rx_valid", {7'd0, rx_valid}, 8'h00);
        check("t5_datain", DATAin, 8'h00);
        wait_clks(2);
        rst = 1'b0;
        wait_clks(4);
        CS = 1'b1;
        wait_clks(6);
        load_tx(8'hE7);
        cs_begin();
        spi_bits(8'h5A, 8, got);
        cs_end();
        check("t5_miso_byte", got, 8'hE7);
        check("t5_datain_5a", DATAin, 8'h5A);
        check("t5_valid_5a", {7'd0, rx_valid}, 8'h01);
        check("t5_err_5a", {5'd0, err}, 8'h00);

        // 6: rx_ack lands on the completing sck_rise (3 clk sync/edge lag)
        cs_begin();
        spi_bits(8'hE1, 7, got);
        MoSi = 1'b1;
        wait_clks(4);
        SCK = 1'b1;
        wait_clks(2);
        rx_ack = 1'b1;
        wait_clks(1);
        rx_ack = 1'b0;
        wait_clks(1);
        SCK = 1'b0;
        cs_end();
        check("t6_rx_valid", {7'd0, rx_valid}, 8'h01);
        check("t6_datain", DATAin, 8'hE1);
        check("t6_err", {5'd0, err}, 8'h01);
        pulse_clr();
        check("t6_err_clr", {5'd0, err}, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
